tx_mailbox: RTL and testbench
=============================

TX_MAILBOX -- requirements
Module: tx_mailbox

Interface
REQ-001 SHALL have parameter RETRY_LIMIT, default 8, range 1..15: failed attempts before a mailbox is dropped.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load_mb  input  1  host write strobe; captures the frame below into mailbox mb_sel.
REQ-005 SHALL have port mb_sel  input  2  target mailbox 0..3.
REQ-006 SHALL have ports ID_in  input  29  frame ID (standard frames use ID_in[10:0]); RTR_in, EXT_in  input  1 each.
REQ-007 SHALL have ports pkt_size_in  input  4  DLC; data_L_in, data_H_in  input  32 each  bytes 0-3 and 4-7 (byte n at {data_H_in,data_L_in}[8n+:8]).
REQ-008 SHALL have port abort_mb  input  4  per-mailbox abort request, one-cycle pulses.
REQ-009 SHALL have port clear_status  input  1  clears tx_complete and tx_failed.
REQ-010 SHALL have ports tx_start, tx_done, arb_lost, tx_error  input  1 each  one-cycle pulses from the bit engine.
REQ-011 SHALL have port byte_index  input  4  data byte the engine requests.
REQ-012 SHALL have ports tx_req  output  1; tx_ID  output  29; tx_RTR, tx_EXT  output  1 each; tx_pkt_size  output  4.
REQ-013 SHALL have port tx_data  output  8  requested data byte.
REQ-014 SHALL have ports pending, tx_complete, tx_failed  output  4 each  per-mailbox status; busy  output  1  FSM not IDLE; load_err  output  1.

Function
REQ-015 SHALL use FSM states IDLE, SELECT, REQ, ACTIVE.
REQ-016 IDLE->SELECT when pending != 0 and no abort is pulsing; otherwise stay in IDLE.
REQ-017 SELECT (one cycle): latch winner index; drive tx_ID/RTR/EXT/pkt_size from the winner; ->REQ.
REQ-018 Priority key, 32 bits, lowest value wins: standard {ID[10:0],RTR,1'b0,19'b0}; extended {ID[28:18],1'b1,1'b1,ID[17:0],RTR}; on equal keys the lower mailbox index wins.
REQ-019 REQ: tx_req=1; on tx_start ->ACTIVE, tx_req=0 in the next cycle.
REQ-020 ACTIVE, tx_done: clear pending, set tx_complete, reset the retry count; ->IDLE.
REQ-021 ACTIVE, arb_lost: mailbox stays pending, retry count unchanged; ->IDLE, so the next SELECT re-arbitrates.
REQ-022 ACTIVE, tx_error: retry count +1; if it reaches RETRY_LIMIT, clear pending and set tx_failed; ->IDLE.
REQ-023 If more than one of tx_done/arb_lost/tx_error is asserted, tx_done wins over tx_error, and tx_error wins over arb_lost.
REQ-024 tx_data SHALL be registered, 1-cycle latency, from the selected mailbox; 0 when byte_index >= min(pkt_size,8) or tx_RTR=1.
REQ-025 tx_pkt_size SHALL pass the raw DLC; the data length is min(DLC,8).
REQ-026 load_mb to a non-selected mailbox: overwrite its contents, set pending, clear its tx_complete/tx_failed, reset its retry count.
REQ-027 load_mb to the mailbox selected in SELECT/REQ/ACTIVE: ignored; load_err pulses for 1 cycle.
REQ-028 abort of a non-selected mailbox: clear pending in the next cycle.
REQ-029 abort of the selected mailbox in SELECT or REQ: clear pending, drop tx_req, ->IDLE.
REQ-030 abort of the selected mailbox in ACTIVE: latched and deferred to frame end; tx_done still completes the mailbox; arb_lost/tx_error clear pending without setting tx_failed.
REQ-031 tx_start outside REQ, and tx_done/arb_lost/tx_error outside ACTIVE, SHALL be ignored.
REQ-032 clear_status has priority over any same-cycle set of tx_complete/tx_failed.

Reset
REQ-033 On RST: FSM=IDLE; all outputs 0; pending/tx_complete/tx_failed=0; retry counts=0; mailbox contents=0; RST overrides all inputs, including mid-frame.

Verification
REQ-034 Load mb2 with ID 0x123 std, DLC 2, data_L 0xBBAA; tx_start, read byte_index 0,1,2 -> tx_req 2 cycles after load; tx_data AA, BB, 00; tx_done -> tx_complete=0100, pending=0.
REQ-035 Load mb0 ext ID 0x0123_4567 and mb3 std ID 0x048 (base bits equal) -> mb3 wins; mb0 is sent next.
REQ-036 With RETRY_LIMIT=2, give mb1 two tx_error pulses -> pending[1]=0, tx_failed=0010; arb_lost alone leaves mb1 pending.
REQ-037 Abort mb1 in REQ -> tx_req drops the next cycle, pending=0; abort in ACTIVE followed by tx_done -> tx_complete[1]=1.
REQ-038 Load the active mailbox -> load_err pulse, contents unchanged; assert RST mid-ACTIVE -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/tx_mailbox.sv
// Four-mailbox transmit scheduler for a CAN-style bit engine: arbitrates pending
// frames by priority key, hands the winner to the engine, and tracks completion, retries and aborts.
module tx_mailbox #(
  parameter int RETRY_LIMIT = 8
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        load_mb,
  input  logic [1:0]  mb_sel,
  input  logic [28:0] ID_in,
  input  logic        RTR_in,
  input  logic        EXT_in,
  input  logic [3:0]  pkt_size_in,
  input  logic [31:0] data_L_in,
  input  logic [31:0] data_H_in,
  input  logic [3:0]  abort_mb,
  input  logic        clear_status,
  input  logic        tx_start,
  input  logic        tx_done,
  input  logic        arb_lost,
  input  logic        tx_error,
  input  logic [3:0]  byte_index,
  output logic        tx_req,
  output logic [28:0] tx_ID,
  output logic        tx_RTR,
  output logic        tx_EXT,
  output logic [3:0]  tx_pkt_size,
  output logic [7:0]  tx_data,
  output logic [3:0]  pending,
  output logic [3:0]  tx_complete,
  output logic [3:0]  tx_failed,
  output logic        busy,
  output logic        load_err
);
  typedef enum logic [1:0] {IDLE, SELECT, REQ, ACTIVE} state_t;

  state_t      state_reg, state_next;
  logic [28:0] id_mem   [4];
  logic        rtr_mem  [4];
  logic        ext_mem  [4];
  logic [3:0]  dlc_mem  [4];
  logic [63:0] data_mem [4];
  logic [3:0]  retry_reg  [4];
  logic [3:0]  retry_next [4];
  logic [3:0]  pending_reg, pending_next;
  logic [3:0]  complete_reg, complete_next;
  logic [3:0]  failed_reg, failed_next;
  logic [1:0]  sel_reg;
  logic        abort_latched_reg, abort_latched_next;
  logic [28:0] tx_id_reg;
  logic        tx_rtr_reg, tx_ext_reg;
  logic [3:0]  tx_dlc_reg;
  logic [7:0]  tx_data_reg;
  logic        load_err_reg;

  logic [31:0] key [4];
  logic [1:0]  win_idx;
  logic [31:0] win_key;
  logic        win_found;
  logic        in_frame, sel_abort, load_hit, load_ok, abort_eff;
  logic        end_done, end_error, end_arb;
  logic [1:0]  cur_sel;
  logic [4:0]  retry_inc;
  logic [3:0]  data_len;
  logic [63:0] sel_data;

  // Lower key wins; extended frames lose to a standard frame with the same base ID.
  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    assign key[gi] = ext_mem[gi] ? {id_mem[gi][28:18], 1'b1, 1'b1, id_mem[gi][17:0], rtr_mem[gi]}
                                 : {id_mem[gi][10:0], rtr_mem[gi], 1'b0, 19'b0};
  end

  always_comb begin
    win_idx   = 2'd0;
    win_key   = '1;
    win_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pending_reg[i] && (!win_found || key[i] < win_key)) begin
        win_idx   = 2'(i);
        win_key   = key[i];
        win_found = 1'b1;
      end
    end
  end

  // While in SELECT the candidate is still the live arbitration result.
  assign in_frame  = (state_reg != IDLE);
  assign cur_sel   = (state_reg == SELECT) ? win_idx : sel_reg;
  assign sel_abort = in_frame && abort_mb[cur_sel];
  assign load_hit  = load_mb && in_frame && (mb_sel == cur_sel);
  assign load_ok   = load_mb && !load_hit;
  assign end_done  = (state_reg == ACTIVE) && tx_done;
  assign end_error = (state_reg == ACTIVE) && !tx_done && tx_error;
  assign end_arb   = (state_reg == ACTIVE) && !tx_done && !tx_error && arb_lost;
  assign abort_eff = abort_latched_reg || abort_mb[sel_reg];
  assign retry_inc = {1'b0, retry_reg[sel_reg]} + 5'd1;
  assign data_len  = (tx_dlc_reg > 4'd8) ? 4'd8 : tx_dlc_reg;
  assign sel_data  = data_mem[sel_reg] >> {byte_index[2:0], 3'b000};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pending_reg != 4'b0 && abort_mb == 4'b0) state_next = SELECT;
      SELECT:  state_next = sel_abort ? IDLE : REQ;
      REQ: begin
        if (sel_abort)     state_next = IDLE;
        else if (tx_start) state_next = ACTIVE;
      end
      ACTIVE:  if (tx_done || tx_error || arb_lost) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pending_next  = pending_reg;
    complete_next = complete_reg;
    failed_next   = failed_reg;
    for (int i = 0; i < 4; i++) retry_next[i] = retry_reg[i];
    if (load_ok) begin
      pending_next[mb_sel]  = 1'b1;
      complete_next[mb_sel] = 1'b0;
      failed_next[mb_sel]   = 1'b0;
      retry_next[mb_sel]    = 4'd0;
    end
    // An abort on the frame on the bus is deferred until the engine reports its end.
    for (int i = 0; i < 4; i++) begin
      if (abort_mb[i] && !(state_reg == ACTIVE && sel_reg == 2'(i))) pending_next[i] = 1'b0;
    end
    if (end_done) begin
      pending_next[sel_reg]  = 1'b0;
      complete_next[sel_reg] = 1'b1;
      retry_next[sel_reg]    = 4'd0;
    end
    if (end_error) begin
      if (abort_eff) begin
        pending_next[sel_reg] = 1'b0;
      end else if (retry_inc >= 5'(RETRY_LIMIT)) begin
        pending_next[sel_reg] = 1'b0;
        failed_next[sel_reg]  = 1'b1;
        retry_next[sel_reg]   = 4'd0;
      end else begin
        retry_next[sel_reg] = retry_inc[3:0];
      end
    end
    if (end_arb && abort_eff) pending_next[sel_reg] = 1'b0;
    if (clear_status) begin
      complete_next = 4'b0;
      failed_next   = 4'b0;
    end
    abort_latched_next = (state_reg == ACTIVE && state_next == ACTIVE) ? abort_eff : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg         <= IDLE;
      pending_reg       <= 4'b0;
      complete_reg      <= 4'b0;
      failed_reg        <= 4'b0;
      sel_reg           <= 2'd0;
      abort_latched_reg <= 1'b0;
      tx_id_reg         <= 29'd0;
      tx_rtr_reg        <= 1'b0;
      tx_ext_reg        <= 1'b0;
      tx_dlc_reg        <= 4'd0;
      tx_data_reg       <= 8'd0;
      load_err_reg      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        id_mem[i]    <= 29'd0;
        rtr_mem[i]   <= 1'b0;
        ext_mem[i]   <= 1'b0;
        dlc_mem[i]   <= 4'd0;
        data_mem[i]  <= 64'd0;
        retry_reg[i] <= 4'd0;
      end
    end else begin
      state_reg         <= state_next;
      pending_reg       <= pending_next;
      complete_reg      <= complete_next;
      failed_reg        <= failed_next;
      abort_latched_reg <= abort_latched_next;
      load_err_reg      <= load_hit;
      for (int i = 0; i < 4; i++) retry_reg[i] <= retry_next[i];
      if (load_ok) begin
        id_mem[mb_sel]   <= ID_in;
        rtr_mem[mb_sel]  <= RTR_in;
        ext_mem[mb_sel]  <= EXT_in;
        dlc_mem[mb_sel]  <= pkt_size_in;
        data_mem[mb_sel] <= {data_H_in, data_L_in};
      end
      if (state_reg == SELECT && state_next == REQ) begin
        sel_reg    <= win_idx;
        tx_id_reg  <= id_mem[win_idx];
        tx_rtr_reg <= rtr_mem[win_idx];
        tx_ext_reg <= ext_mem[win_idx];
        tx_dlc_reg <= dlc_mem[win_idx];
      end
      tx_data_reg <= ((state_reg == REQ || state_reg == ACTIVE) && !tx_rtr_reg && byte_index < data_len)
                     ? sel_data[7:0] : 8'd0;
    end
  end

  assign tx_req      = (state_reg == REQ);
  assign busy        = in_frame;
  assign tx_ID       = tx_id_reg;
  assign tx_RTR      = tx_rtr_reg;
  assign tx_EXT      = tx_ext_reg;
  assign tx_pkt_size = tx_dlc_reg;
  assign tx_data     = tx_data_reg;
  assign pending     = pending_reg;
  assign tx_complete = complete_reg;
  assign tx_failed   = failed_reg;
  assign load_err    = load_err_reg;
endmodule

// File: tb/tb_tx_mailbox.sv
// Bench for tx_mailbox: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the mailboxes.
module tb_tx_mailbox;
  localparam int LIMIT = 2;

  logic        clk;
  logic        RST;
  logic        load_mb;
  logic [1:0]  mb_sel;
  logic [28:0] ID_in;
  logic        RTR_in, EXT_in;
  logic [3:0]  pkt_size_in;
  logic [31:0] data_L_in, data_H_in;
  logic [3:0]  abort_mb;
  logic        clear_status;
  logic        tx_start, tx_done, arb_lost, tx_error;
  logic [3:0]  byte_index;
  logic        tx_req;
  logic [28:0] tx_ID;
  logic        tx_RTR, tx_EXT;
  logic [3:0]  tx_pkt_size;
  logic [7:0]  tx_data;
  logic [3:0]  pending, tx_complete, tx_failed;
  logic        busy, load_err;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  tx_mailbox #(.RETRY_LIMIT(LIMIT)) dut (
    .clk(clk), .RST(RST), .load_mb(load_mb), .mb_sel(mb_sel), .ID_in(ID_in),
    .RTR_in(RTR_in), .EXT_in(EXT_in), .pkt_size_in(pkt_size_in),
    .data_L_in(data_L_in), .data_H_in(data_H_in), .abort_mb(abort_mb),
    .clear_status(clear_status), .tx_start(tx_start), .tx_done(tx_done),
    .arb_lost(arb_lost), .tx_error(tx_error), .byte_index(byte_index),
    .tx_req(tx_req), .tx_ID(tx_ID), .tx_RTR(tx_RTR), .tx_EXT(tx_EXT),
    .tx_pkt_size(tx_pkt_size), .tx_data(tx_data), .pending(pending),
    .tx_complete(tx_complete), .tx_failed(tx_failed), .busy(busy), .load_err(load_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Model: phase 0 = nothing in flight, 1 = choosing, 2 = offered to engine, 3 = on the bus.
  int         m_phase;
  int         m_sel;
  bit         m_abort;
  bit [28:0]  m_idv  [4];
  bit         m_rtrv [4];
  bit         m_extv [4];
  bit [3:0]   m_dlcv [4];
  bit [7:0]   m_bytes [4][8];
  int         m_retry [4];
  bit [3:0]   m_pend, m_comp, m_fail;
  bit [28:0]  m_oid;
  bit         m_ortr, m_oext, m_lerr;
  bit [3:0]   m_odlc;
  bit [7:0]   m_odata;

  function automatic longint key_of(int i);
    if (m_extv[i])
      return longint'(m_idv[i] >> 18) * (1 << 21) + (1 << 20) + (1 << 19)
             + longint'(m_idv[i] & 29'h3FFFF) * 2 + longint'(m_rtrv[i]);
    return longint'(m_idv[i] & 29'h7FF) * (1 << 21) + longint'(m_rtrv[i]) * (1 << 20);
  endfunction

  function automatic int best_mb();
    int idx = -1;
    longint bk = 0;
    for (int i = 0; i < 4; i++)
      if (m_pend[i] && (idx < 0 || key_of(i) < bk)) begin
        idx = i;
        bk = key_of(i);
      end
    return (idx < 0) ? 0 : idx;
  endfunction

  task automatic model_step();
    int ph, cur, len;
    bit [3:0] p, c, f;
    bit ab;
    if (RST) begin
      m_phase = 0; m_sel = 0; m_abort = 0;
      m_pend = 0; m_comp = 0; m_fail = 0;
      m_oid = 0; m_ortr = 0; m_oext = 0; m_odlc = 0; m_odata = 0; m_lerr = 0;
      for (int i = 0; i < 4; i++) begin
        m_idv[i] = 0; m_rtrv[i] = 0; m_extv[i] = 0; m_dlcv[i] = 0; m_retry[i] = 0;
        for (int b = 0; b < 8; b++) m_bytes[i][b] = 0;
      end
      return;
    end
    ph  = m_phase;
    cur = (ph == 1) ? best_mb() : m_sel;
    p = m_pend; c = m_comp; f = m_fail;
    len = (m_odlc > 8) ? 8 : int'(m_odlc);
    if ((ph == 2 || ph == 3) && !m_ortr && int'(byte_index) < len) m_odata = m_bytes[m_sel][byte_index];
    else m_odata = 0;
    m_lerr = load_mb && ph != 0 && int'(mb_sel) == cur;
    if (load_mb && !m_lerr) begin
      m_idv[mb_sel] = ID_in; m_rtrv[mb_sel] = RTR_in; m_extv[mb_sel] = EXT_in;
      m_dlcv[mb_sel] = pkt_size_in;
      for (int b = 0; b < 4; b++) begin
        m_bytes[mb_sel][b]     = data_L_in[8*b +: 8];
        m_bytes[mb_sel][b + 4] = data_H_in[8*b +: 8];
      end
      p[mb_sel] = 1; c[mb_sel] = 0; f[mb_sel] = 0; m_retry[mb_sel] = 0;
    end
    for (int i = 0; i < 4; i++)
      if (abort_mb[i] && !(ph == 3 && i == cur)) p[i] = 0;
    case (ph)
      0: if (m_pend != 0 && abort_mb == 0) m_phase = 1;
      1: if (abort_mb[cur]) m_phase = 0;
         else begin
           m_phase = 2; m_sel = cur;
           m_oid = m_idv[cur]; m_ortr = m_rtrv[cur]; m_oext = m_extv[cur]; m_odlc = m_dlcv[cur];
         end
      2: if (abort_mb[cur]) m_phase = 0; else if (tx_start) m_phase = 3;
      default: begin
        ab = m_abort || abort_mb[cur];
        if (tx_done) begin
          p[cur] = 0; c[cur] = 1; m_retry[cur] = 0; m_phase = 0;
        end else if (tx_error) begin
          m_phase = 0;
          if (ab) p[cur] = 0;
          else begin
            m_retry[cur]++;
            if (m_retry[cur] >= LIMIT) begin p[cur] = 0; f[cur] = 1; m_retry[cur] = 0; end
          end
        end else if (arb_lost) begin
          m_phase = 0;
          if (ab) p[cur] = 0;
        end
        m_abort = (m_phase == 3) ? ab : 0;
      end
    endcase
    if (clear_status) begin c = 0; f = 0; end
    m_pend = p; m_comp = c; m_fail = f;
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_tx_req", tx_req, m_phase == 2);
      chk("m_busy", busy, m_phase != 0);
      chk("m_tx_ID", tx_ID, m_oid);
      chk("m_tx_RTR", tx_RTR, m_ortr);
      chk("m_tx_EXT", tx_EXT, m_oext);
      chk("m_tx_pkt_size", tx_pkt_size, m_odlc);
      chk("m_tx_data", tx_data, m_odata);
      chk("m_pending", pending, m_pend);
      chk("m_tx_complete", tx_complete, m_comp);
      chk("m_tx_failed", tx_failed, m_fail);
      chk("m_load_err", load_err, m_lerr);
    end
  end

  task automatic cyc();
    @(negedge clk);
    load_mb = 0; abort_mb = 0; clear_status = 0; RST = 0;
    tx_start = 0; tx_done = 0; arb_lost = 0; tx_error = 0;
  endtask

  task automatic load(input logic [1:0] mb, input logic [28:0] id, input logic ext,
                      input logic rtr, input logic [3:0] dlc, input logic [31:0] dl);
    load_mb = 1; mb_sel = mb; ID_in = id; EXT_in = ext; RTR_in = rtr;
    pkt_size_in = dlc; data_L_in = dl; data_H_in = 32'h8877_6655;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!tx_req && k < 20) begin
      cyc();
      k++;
    end
    chk(tag, tx_req, 1);
  endtask

  initial begin
    RST = 1; load_mb = 0; mb_sel = 0; ID_in = 0; RTR_in = 0; EXT_in = 0;
    pkt_size_in = 0; data_L_in = 0; data_H_in = 0; abort_mb = 0; clear_status = 0;
    tx_start = 0; tx_done = 0; arb_lost = 0; tx_error = 0; byte_index = 0;
    @(negedge clk);
    cmp_en = 1;
    RST = 1;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_tx_req", tx_req, 0);

    // Basic frame: mb2, std 0x123, two data bytes.
    load(2, 29'h123, 0, 0, 2, 32'h0000_BBAA);
    cyc();
    chk("req_not_yet", tx_req, 0);
    cyc();
    chk("req_in_select", tx_req, 0);
    cyc();
    chk("req_two_after_load", tx_req, 1);
    byte_index = 0; tx_start = 1;
    cyc();
    chk("req_drop_on_start", tx_req, 0);
    chk("data_b0", tx_data, 8'hAA);
    byte_index = 1;
    cyc();
    chk("data_b1", tx_data, 8'hBB);
    byte_index = 2;
    cyc();
    chk("data_b2_beyond_dlc", tx_data, 8'h00);
    tx_done = 1;
    cyc();
    chk("done_complete", tx_complete, 4'b0100);
    chk("done_pending", pending, 4'b0000);

    // Standard beats extended with equal base ID.
    clear_status = 1;
    cyc();
    load(0, 29'h0123_4567, 1, 0, 8, 32'h1);
    cyc();
    load(3, 29'h048, 0, 0, 1, 32'h2);
    cyc();
    wait_req("prio_req1");
    chk("prio_first_id", tx_ID, 29'h048);
    tx_start = 1; cyc();
    tx_done = 1; cyc();
    wait_req("prio_req2");
    chk("prio_second_id", tx_ID, 29'h0123_4567);
    chk("prio_second_ext", tx_EXT, 1);
    tx_start = 1; cyc();
    tx_done = 1; cyc();
    chk("prio_complete", tx_complete, 4'b1001);

    // Retry limit of 2 with an arb_lost in between.
    clear_status = 1; cyc();
    load(1, 29'h200, 0, 0, 4, 32'h3);
    cyc();
    wait_req("retry_req1");
    tx_start = 1; cyc();
    tx_error = 1; cyc();
    chk("retry_one_error", pending, 4'b0010);
    wait_req("retry_req2");
    tx_start = 1; cyc();
    arb_lost = 1; cyc();
    chk("arb_keeps_pending", pending, 4'b0010);
    chk("arb_no_fail", tx_failed, 4'b0000);
    wait_req("retry_req3");
    tx_start = 1; cyc();
    tx_error = 1; cyc();
    chk("retry_limit_pending", pending, 4'b0000);
    chk("retry_limit_failed", tx_failed, 4'b0010);

    // Abort in REQ, then abort deferred while ACTIVE.
    clear_status = 1; cyc();
    load(1, 29'h300, 0, 0, 0, 32'h4);
    cyc();
    wait_req("abort_req1");
    abort_mb = 4'b0010; cyc();
    chk("abort_req_drop", tx_req, 0);
    chk("abort_req_pending", pending, 4'b0000);
    load(1, 29'h300, 0, 0, 0, 32'h4);
    cyc();
    wait_req("abort_req2");
    tx_start = 1; cyc();
    abort_mb = 4'b0010; cyc();
    chk("abort_active_deferred", pending, 4'b0010);
    tx_done = 1; cyc();
    chk("abort_active_complete", tx_complete, 4'b0010);
    chk("abort_active_pending", pending, 4'b0000);

    // Load to the active mailbox is rejected; reset mid-frame.
    load(1, 29'h100, 0, 0, 1, 32'h0000_00AA);
    cyc();
    wait_req("lerr_req");
    tx_start = 1; byte_index = 0; cyc();
    load(1, 29'h555, 0, 0, 3, 32'h0000_0077);
    cyc();
    chk("lerr_pulse", load_err, 1);
    chk("lerr_id_kept", tx_ID, 29'h100);
    cyc();
    chk("lerr_one_cycle", load_err, 0);
    chk("lerr_data_kept", tx_data, 8'hAA);
    RST = 1; cyc();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_id", tx_ID, 0);
    chk("rst_mid_data", tx_data, 0);
    chk("rst_mid_pending", pending, 0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(99) < 15) begin
        load_mb = 1;
        mb_sel = 2'($urandom_range(3));
        ID_in = $urandom_range(1) ? 29'($urandom) : 29'($urandom_range(3)) * 29'h40000;
        EXT_in = 1'($urandom_range(1));
        RTR_in = ($urandom_range(3) == 0);
        pkt_size_in = 4'($urandom_range(15));
        data_L_in = $urandom;
        data_H_in = $urandom;
      end
      if ($urandom_range(99) < 5) begin
        abort_mb = 4'(1 << $urandom_range(3));
        if (load_mb) abort_mb[mb_sel] = 0;
      end
      clear_status = ($urandom_range(99) < 4);
      tx_start = (m_phase == 2) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 3);
      if (m_phase == 2 && abort_mb[m_sel]) tx_start = 0;
      if ((m_phase == 3) ? ($urandom_range(99) < 35) : ($urandom_range(99) < 3))
        {tx_done, tx_error, arb_lost} = 3'($urandom_range(7, 1));
      byte_index = 4'($urandom_range(15));
      RST = ($urandom_range(299) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
